// File: rtl/bomb_field_placer.sv
// rtl/bomb_field_placer.sv - random bomb placement on an 8x8 board via LFSR draw and linear probing
// Optional SAFE_CELL_EN: adds safe_cell input; that cell never receives a bomb.
module bomb_field_placer #(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  bomb_count,
`ifdef SAFE_CELL_EN
  input  logic [5:0]  safe_cell,
`endif
  output logic [63:0] board,
  output logic [5:0]  bombs_placed,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAW  = 2'd1,
    S_PROBE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [LFSR_W-1:0] lfsr;
  logic [5:0]        ptr;
  logic [5:0]        target;
  logic              excluded;
  logic              cell_free;
  logic              last_bomb;
  logic              accept;

`ifdef SAFE_CELL_EN
  logic [5:0] safe_q;
  assign excluded = (ptr == safe_q);
`else
  assign excluded = 1'b0;
`endif

  assign cell_free = !board[ptr] && !excluded;
  assign last_bomb = (bombs_placed + 6'd1) == target;
  assign accept    = start && (state == S_IDLE || state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nxt = (bomb_count == 6'd0) ? S_DONE : S_DRAW;
      end
      S_DRAW:  state_nxt = S_PROBE;
      S_PROBE: begin
        if (cell_free) state_nxt = last_bomb ? S_DONE : S_DRAW;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_DRAW, S_PROBE: busy = 1'b1;
      S_DONE:          done = 1'b1;
      default: ;
    endcase
  end

  // The LFSR free-runs in every state so start timing contributes entropy.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr         <= LFSR_SEED;
      board        <= '0;
      bombs_placed <= '0;
      ptr          <= '0;
      target       <= '0;
`ifdef SAFE_CELL_EN
      safe_q       <= '0;
`endif
    end else begin
      lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
      if (accept) begin
        target       <= bomb_count;
        board        <= '0;
        bombs_placed <= '0;
`ifdef SAFE_CELL_EN
        safe_q       <= safe_cell;
`endif
      end
      if (state == S_DRAW) ptr <= lfsr[5:0];
      if (state == S_PROBE) begin
        if (cell_free) begin
          board[ptr]   <= 1'b1;
          bombs_placed <= bombs_placed + 6'd1;
        end else begin
          ptr <= ptr + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bomb_field_placer.sv
// tb/tb_bomb_field_placer.sv - directed self-checking bench for bomb_field_placer
// Build with SAFE_CELL_EN defined to exercise the safe-cell variant.
module tb_bomb_field_placer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  bomb_count = '0;
  logic [5:0]  safe_cell = '0;
  logic [63:0] board;
  logic [5:0]  bombs_placed;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  bit inv_ok;
  int cyc;

  always #5 clk = ~clk;

  bomb_field_placer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bomb_count   (bomb_count),
`ifdef SAFE_CELL_EN
    .safe_cell    (safe_cell),
`endif
    .board        (board),
    .bombs_placed (bombs_placed),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start accepted on the posedge following this call; returns at the next negedge.
  task automatic pulse_start(input logic [5:0] n);
    bomb_count = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    cyc = 0;
    while (!done && cyc < max_cycles) begin
      if ($countones(board) != int'(bombs_placed)) inv_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    inv_ok = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_board", board, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_placed", {58'h0, bombs_placed}, 64'h0);
    check("rst_lfsr", {48'h0, dut.lfsr}, 64'hACE1);
    rst = 1'b0;
    @(negedge clk);

    pulse_start(6'd2);
    check("two_busy", {63'h0, busy}, 64'h1);
    wait_done(131);
    check("two_done", {63'h0, done}, 64'h1);
    check("two_pop", $countones(board), 64'd2);
    check("two_placed", {58'h0, bombs_placed}, 64'd2);
    repeat (5) @(negedge clk);
    check("two_hold", {63'h0, done}, 64'h1);
    check("two_hold_pop", $countones(board), 64'd2);

    pulse_start(6'd0);
    check("zero_done", {63'h0, done}, 64'h1);
    check("zero_busy", {63'h0, busy}, 64'h0);
    check("zero_board", board, 64'h0);

    safe_cell = 6'd27;
    pulse_start(6'd63);
    safe_cell = 6'd5;
    wait_done(4096);
    check("full_done", {63'h0, done}, 64'h1);
    check("full_pop", $countones(board), 64'd63);
    check("full_placed", {58'h0, bombs_placed}, 64'd63);
`ifdef SAFE_CELL_EN
    check("full_safe", board, ~(64'h1 << 27));
`endif

    pulse_start(6'd32);
    repeat (3) @(negedge clk);
    pulse_start(6'd4);
    wait_done(2081);
    check("ign_done", {63'h0, done}, 64'h1);
    check("ign_pop", $countones(board), 64'd32);
    check("ign_placed", {58'h0, bombs_placed}, 64'd32);

    pulse_start(6'd32);
    cyc = 0;
    while (bombs_placed != 6'd10 && cyc < 700) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_reach10", {58'h0, bombs_placed}, 64'd10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_board", board, 64'h0);
    check("mid_placed", {58'h0, bombs_placed}, 64'h0);
    check("mid_busy", {63'h0, busy}, 64'h0);
    check("mid_done", {63'h0, done}, 64'h0);

    pulse_start(6'd8);
    wait_done(521);
    check("eight_done", {63'h0, done}, 64'h1);
    check("eight_pop", $countones(board), 64'd8);
    check("eight_placed", {58'h0, bombs_placed}, 64'd8);
    check("invariant", {63'h0, inv_ok}, 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
